// File: rtl/fetch_controller_if.sv
// Fetch-unit side bus of the fetch controller: address load strobes out,
// registered instruction back.
interface fetch_controller_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 16
);
    logic               en_pc;
    logic               en_new_pc;
    logic [ADDR_W-1:0]  new_pc;
    logic [INSTR_W-1:0] instr_in;

    modport master (
        output en_pc,
        output en_new_pc,
        output new_pc,
        input  instr_in
    );

    modport slave (
        input  en_pc,
        input  en_new_pc,
        input  new_pc,
        output instr_in
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC and issues every fetch as an explicit address load.
// Optional performance counters are enabled with the FETCH_CTRL_PERF_EN macro.
module fetch_controller #(
    parameter int         ADDR_W      = 12,
    parameter int         INSTR_W     = 16,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    fetch_controller_if.master fetch,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc_q;
    logic              issue;
    logic [ADDR_W-1:0] issue_pc;
    logic              halt_op;

    // Only a live instruction can halt; a stale instr_in is ignored.
    assign halt_op = instr_valid && (fetch.instr_in[INSTR_W-1 -: 4] == HALT_OPCODE);

    always_comb begin
        issue    = 1'b0;
        issue_pc = pc_q;
        if (!reset) begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        issue    = 1'b1;
                        issue_pc = start_pc;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        issue = 1'b0;
                    end else if (branch_valid) begin
                        issue    = 1'b1;
                        issue_pc = branch_target;
                    end else if (stall || halt_op) begin
                        issue = 1'b0;
                    end else begin
                        issue = 1'b1;
                    end
                end
                default: issue = 1'b0;
            endcase
        end
    end

    assign fetch.en_pc     = 1'b0;
    assign fetch.en_new_pc = issue;
    assign fetch.new_pc    = issue_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc_q        <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (issue) begin
                pc_q        <= issue_pc + 1'b1;
                instr_pc    <= issue_pc;
                instr_valid <= 1'b1;
            end
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end
                RUN: begin
                    // Stall holds everything, so the halt opcode only fires once consumed.
                    if (halt_req || (!branch_valid && !stall && halt_op)) begin
                        instr_valid <= 1'b0;
                        state       <= HALTED;
                        halted      <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state == RUN) && stall && instr_valid && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
